axi_r_arbiter: RTL and testbench
================================

# axi_r_arbiter

Two-master read arbiter in front of the single SRAM-backed AXI read slave. It shares that slave between the instruction-fetch port (M0) and the data-load port (M1). Arbitration is round-robin, and each grant covers a whole burst. A beat counter checks the slave's burst termination, and any fault sets a sticky protocol-error flag. The block sits between the core's two read ports and the AXI read slave.

## Interface
- DATA_WIDTH, 32, R data width
- ADDR_WIDTH, 32, AR address width
- ACLK  input  1  clock; all logic on rising edge
- ARESET  input  1  synchronous, active-high reset
- M0_ARADDR / M1_ARADDR  input  ADDR_WIDTH  master read address
- M0_ARLEN / M1_ARLEN  input  8  burst length minus 1
- M0_ARSIZE / M1_ARSIZE  input  3  beat size
- M0_ARBURST / M1_ARBURST  input  2  burst type
- M0_ARVALID / M1_ARVALID  input  1  address request
- M0_ARREADY / M1_ARREADY  output  1  address accept
- M0_RDATA / M1_RDATA  output  DATA_WIDTH  read data
- M0_RRESP / M1_RRESP  output  2  read response
- M0_RLAST / M1_RLAST  output  1  last beat
- M0_RVALID / M1_RVALID  output  1  data valid
- M0_RREADY / M1_RREADY  input  1  master data accept
- S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID  output  as master  AR to slave
- S_ARREADY  input  1  slave address accept
- S_RDATA, S_RRESP, S_RLAST, S_RVALID  input  as master  R from slave
- S_RREADY  output  1  to slave
- grant  output  1  current owner (0 = M0, 1 = M1)
- busy  output  1  state is not IDLE
- proto_err  output  1  sticky burst-termination error

## Operation
- The FSM has three states: IDLE, ADDR and DATA.
- IDLE:
  - If any Mx_ARVALID is asserted, register the grant and go to ADDR.
  - If only one master requests, that master wins.
  - If both request, the master not granted last wins.
  - The last-grant pointer resets to 1, so M0 wins the first tie.
- ADDR: route the granted master's AR signals to the S_AR outputs.
  - Drive S_ARVALID = Mg_ARVALID and Mg_ARREADY = S_ARREADY.
  - The non-granted ARREADY is 0.
  - On S_ARVALID && S_ARREADY, load beat_cnt = S_ARLEN and go to DATA.
- DATA: route the R channel to the granted master.
  - Drive S_RREADY = Mg_RREADY; Mg_RVALID, RDATA and RRESP come from the slave.
  - The non-granted RVALID is 0.
  - Each R handshake decrements beat_cnt.
- End of burst is the R handshake on which S_RLAST=1 or beat_cnt==0. On that handshake:
  - go to IDLE;
  - set the last-grant pointer to grant.
- Termination checks:
  - S_RLAST=1 with beat_cnt!=0 (early last): pass the beat through, end the burst, set proto_err.
  - beat_cnt==0 with S_RLAST=0 (missing last): force Mg_RLAST=1, end the burst, set proto_err.
  - The slave is expected to drop RVALID afterwards.
- proto_err is cleared only by ARESET.
- A master that deasserts ARVALID in ADDR violates AXI. The block stays in ADDR and keeps the grant.

## Timing
- All outputs after reset:
  - state is IDLE;
  - grant=0, busy=0, proto_err=0;
  - every ARREADY=0, every RVALID=0, every RLAST=0;
  - S_ARVALID=0, S_RREADY=0;
  - S_AR* payload=0 and M*_RDATA/RRESP=0, because they are gated by state.
- ARESET in mid-burst returns to IDLE in the next cycle. It also resets the last-grant pointer.
- Arbitration adds one cycle: a request seen in IDLE at cycle N can handshake on the slave at cycle N+1 at the earliest.
- Muxing in ADDR and DATA is combinational from registered grant/state. There is zero added latency on AR or R.
- A burst of ARLEN+1 beats occupies 1 (IDLE) + ≥1 (ADDR) + ARLEN+1 (DATA) cycles. Back-to-back bursts therefore have one idle cycle between them.
- beat_cnt is 8 bits, loaded from ARLEN. The decrement never wraps, because the burst ends at 0.
- Requests arriving in ADDR or DATA are held off with ARREADY=0 until the next IDLE evaluation.

## Test plan
- **Single M0 request.** M0 sends ARADDR=0x100, ARLEN=3; S_ARREADY=1; the slave returns 4 beats with RLAST on beat 4.
  - M0 gets 4 beats; M1_RVALID stays 0; grant=0; proto_err=0; busy drops the cycle after the last handshake.
- **Simultaneous requests, twice.** M0 and M1 both request on the same cycle, each with ARLEN=0, and keep requesting.
  - Grants are M0 then M1; the third burst goes to M0.
  - Each burst is separated by one IDLE cycle.
- **Backpressure.** M1 bursts with ARLEN=7; M1_RREADY toggles 1/0 every cycle.
  - Exactly 8 handshakes; S_RREADY mirrors M1_RREADY; RDATA order is preserved.
- **Early last.** ARLEN=3; the slave asserts RLAST on beat 2.
  - Burst ends after 2 beats; proto_err=1 and stays set through the later clean bursts.
- **Missing last.** ARLEN=1; the slave never asserts RLAST.
  - Mg_RLAST is forced to 1 on beat 2; state returns to IDLE; proto_err=1.
- **Reset mid-burst.** Assert ARESET during DATA.
  - Next cycle: every output is at its reset value and the state is IDLE.
  - After release, a tied request goes to M0.

Source files
------------

// File: rtl/axi_r_arbiter.sv
// Two-master round-robin AXI read arbiter: one grant per whole burst, with a beat
// counter that checks the slave's RLAST and flags any termination fault in proto_err.
module axi_r_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,

  input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
  input  logic [7:0]            M0_ARLEN,
  input  logic [2:0]            M0_ARSIZE,
  input  logic [1:0]            M0_ARBURST,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic [1:0]            M0_RRESP,
  output logic                  M0_RLAST,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,

  input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
  input  logic [7:0]            M1_ARLEN,
  input  logic [2:0]            M1_ARSIZE,
  input  logic [1:0]            M1_ARBURST,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic [1:0]            M1_RRESP,
  output logic                  M1_RLAST,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,

  output logic [ADDR_WIDTH-1:0] S_ARADDR,
  output logic [7:0]            S_ARLEN,
  output logic [2:0]            S_ARSIZE,
  output logic [1:0]            S_ARBURST,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [DATA_WIDTH-1:0] S_RDATA,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RLAST,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,

  output logic                  grant,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic [7:0] beat_cnt;

  logic in_addr;
  logic in_data;
  logic pick;
  logic g_arvalid;
  logic g_rready;
  logic cnt_zero;
  logic r_last;
  logic ar_hs;
  logic r_hs;
  logic term_fault;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  // On a tie the master that did not own the previous burst wins.
  assign pick = (M0_ARVALID && M1_ARVALID) ? ~last_grant : M1_ARVALID;

  assign g_arvalid = grant ? M1_ARVALID : M0_ARVALID;
  assign g_rready  = grant ? M1_RREADY  : M0_RREADY;

  assign S_ARVALID = in_addr & g_arvalid;
  assign S_ARADDR  = in_addr ? (grant ? M1_ARADDR  : M0_ARADDR)  : '0;
  assign S_ARLEN   = in_addr ? (grant ? M1_ARLEN   : M0_ARLEN)   : '0;
  assign S_ARSIZE  = in_addr ? (grant ? M1_ARSIZE  : M0_ARSIZE)  : '0;
  assign S_ARBURST = in_addr ? (grant ? M1_ARBURST : M0_ARBURST) : '0;
  assign M0_ARREADY = in_addr & ~grant & S_ARREADY;
  assign M1_ARREADY = in_addr &  grant & S_ARREADY;
  assign ar_hs      = S_ARVALID & S_ARREADY;

  // A burst ends on the slave's RLAST or when the counter runs out, whichever
  // comes first; the master always sees RLAST on that final beat.
  assign cnt_zero   = (beat_cnt == 8'd0);
  assign r_last     = S_RLAST | cnt_zero;
  assign term_fault = S_RLAST ^ cnt_zero;
  assign S_RREADY   = in_data & g_rready;
  assign r_hs       = in_data & S_RVALID & g_rready;

  assign M0_RVALID = in_data & ~grant & S_RVALID;
  assign M1_RVALID = in_data &  grant & S_RVALID;
  assign M0_RLAST  = in_data & ~grant & r_last;
  assign M1_RLAST  = in_data &  grant & r_last;
  assign M0_RDATA  = (in_data & ~grant) ? S_RDATA : '0;
  assign M1_RDATA  = (in_data &  grant) ? S_RDATA : '0;
  assign M0_RRESP  = (in_data & ~grant) ? S_RRESP : '0;
  assign M1_RRESP  = (in_data &  grant) ? S_RRESP : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= 8'd0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (M0_ARVALID || M1_ARVALID) begin
            grant <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            beat_cnt <= S_ARLEN;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (r_last) begin
              state      <= IDLE;
              last_grant <= grant;
              if (term_fault) begin
                proto_err <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Directed-plus-random bench for axi_r_arbiter: the bench plays the slave and both
// masters, and predicts grants, beats and proto_err from the arbitration rules.
module tb_axi_r_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
  logic [7:0]  M0_ARLEN, M1_ARLEN, S_ARLEN;
  logic [2:0]  M0_ARSIZE, M1_ARSIZE, S_ARSIZE;
  logic [1:0]  M0_ARBURST, M1_ARBURST, S_ARBURST;
  logic        M0_ARVALID, M1_ARVALID, S_ARVALID;
  logic        M0_ARREADY, M1_ARREADY, S_ARREADY;
  logic [31:0] M0_RDATA, M1_RDATA, S_RDATA;
  logic [1:0]  M0_RRESP, M1_RRESP, S_RRESP;
  logic        M0_RLAST, M1_RLAST, S_RLAST;
  logic        M0_RVALID, M1_RVALID, S_RVALID;
  logic        M0_RREADY, M1_RREADY, S_RREADY;
  logic        grant, busy, proto_err;

  int vectors = 0;
  int miscompares = 0;
  bit modelLast = 1'b1;
  bit modelErr = 1'b0;

  axi_r_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .grant(grant), .busy(busy), .proto_err(proto_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic clearInputs();
    M0_ARADDR = '0; M0_ARLEN = '0; M0_ARSIZE = '0; M0_ARBURST = '0; M0_ARVALID = 0; M0_RREADY = 0;
    M1_ARADDR = '0; M1_ARLEN = '0; M1_ARSIZE = '0; M1_ARBURST = '0; M1_ARVALID = 0; M1_RREADY = 0;
    S_ARREADY = 0; S_RDATA = '0; S_RRESP = '0; S_RLAST = 0; S_RVALID = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " grant"}, grant, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " proto_err"}, proto_err, 0);
    checkOutput({tag, " arready"}, {M1_ARREADY, M0_ARREADY}, 0);
    checkOutput({tag, " rvalid"}, {M1_RVALID, M0_RVALID}, 0);
    checkOutput({tag, " rlast"}, {M1_RLAST, M0_RLAST}, 0);
    checkOutput({tag, " rdata"}, {M1_RDATA, M0_RDATA}, 0);
    checkOutput({tag, " rresp"}, {M1_RRESP, M0_RRESP}, 0);
    checkOutput({tag, " s_arvalid"}, S_ARVALID, 0);
    checkOutput({tag, " s_rready"}, S_RREADY, 0);
    checkOutput({tag, " s_ar payload"}, {S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST}, 0);
  endtask

  task automatic doReset();
    clearInputs();
    ARESET = 1;
    tick();
    #1;
    checkReset("reset");
    ARESET = 0;
    modelLast = 1'b1;
    modelErr = 1'b0;
  endtask

  // One complete burst. lastAt is the 1-based beat on which the slave raises RLAST
  // (beyond len+1 means it never does); the winner follows the round-robin rule.
  task automatic applyStimulus(input logic [1:0] req, input int len, input int lastAt,
                               input bit toggle, input int arStall);
    logic        w;
    logic [31:0] addr [2];
    logic [2:0]  sz [2];
    logic [1:0]  bt [2];
    logic [31:0] dataQ [$];
    logic [1:0]  respQ [$];
    int          expBeats;
    int          nHs;
    int          cyc;
    logic        rr;

    w = (req == 2'b11) ? ~modelLast : req[1];
    expBeats = (lastAt <= len + 1) ? lastAt : len + 1;
    for (int i = 0; i < 2; i++) begin
      addr[i] = $urandom & 32'hFFFF_FFF0;
      sz[i]   = 3'($urandom_range(0, 2));
      bt[i]   = 2'($urandom_range(0, 2));
    end
    for (int i = 0; i <= len; i++) begin
      dataQ.push_back($urandom);
      respQ.push_back(2'($urandom_range(0, 3)));
    end

    M0_ARADDR = addr[0]; M0_ARLEN = 8'(len); M0_ARSIZE = sz[0]; M0_ARBURST = bt[0]; M0_ARVALID = req[0];
    M1_ARADDR = addr[1]; M1_ARLEN = 8'(len); M1_ARSIZE = sz[1]; M1_ARBURST = bt[1]; M1_ARVALID = req[1];
    S_ARREADY = 0;
    #1;
    checkOutput("idle busy", busy, 0);
    checkOutput("idle arready", {M1_ARREADY, M0_ARREADY}, 0);
    tick();

    for (int s = 0; s <= arStall; s++) begin
      S_ARREADY = (s == arStall);
      #1;
      checkOutput("addr grant", grant, w);
      checkOutput("addr busy", busy, 1);
      checkOutput("s_arvalid", S_ARVALID, 1);
      checkOutput("s_araddr", S_ARADDR, addr[w]);
      checkOutput("s_arlen", S_ARLEN, len);
      checkOutput("s_arsize", S_ARSIZE, sz[w]);
      checkOutput("s_arburst", S_ARBURST, bt[w]);
      checkOutput("arready", {M1_ARREADY, M0_ARREADY},
                  (s == arStall) ? (w ? 2'b10 : 2'b01) : 2'b00);
      tick();
    end

    if (w) M1_ARVALID = 0; else M0_ARVALID = 0;
    S_ARREADY = 0;
    nHs = 0;
    cyc = 0;
    while (nHs < expBeats) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      S_RVALID = 1;
      S_RDATA  = dataQ[nHs];
      S_RRESP  = respQ[nHs];
      S_RLAST  = (nHs + 1 == lastAt);
      if (w) M1_RREADY = rr; else M0_RREADY = rr;
      #1;
      checkOutput("data busy", busy, 1);
      checkOutput("data grant", grant, w);
      checkOutput("s_rready", S_RREADY, rr);
      checkOutput("rvalid", {M1_RVALID, M0_RVALID}, w ? 2'b10 : 2'b01);
      checkOutput("held arready", {M1_ARREADY, M0_ARREADY}, 0);
      if (rr) begin
        checkOutput("rdata", w ? M1_RDATA : M0_RDATA, dataQ[nHs]);
        checkOutput("rresp", w ? M1_RRESP : M0_RRESP, respQ[nHs]);
        checkOutput("rlast", {M1_RLAST, M0_RLAST},
                    (nHs + 1 == expBeats) ? (w ? 2'b10 : 2'b01) : 2'b00);
        nHs++;
      end
      tick();
      cyc++;
    end

    S_RVALID = 0; S_RLAST = 0; M0_RREADY = 0; M1_RREADY = 0;
    if (lastAt != len + 1) modelErr = 1'b1;
    modelLast = w;
    #1;
    checkOutput("end busy", busy, 0);
    checkOutput("end proto_err", proto_err, modelErr);
    checkOutput("end rvalid", {M1_RVALID, M0_RVALID}, 0);
  endtask

  initial begin
    int len;
    clearInputs();
    ARESET = 1;
    @(negedge ACLK);
    doReset();

    // single M0 burst, clean termination
    applyStimulus(2'b01, 3, 4, 0, 0);

    // simultaneous requests: M0, M1, M0 with one idle cycle between bursts
    doReset();
    applyStimulus(2'b11, 0, 1, 0, 0);
    applyStimulus(2'b11, 0, 1, 0, 0);
    applyStimulus(2'b11, 0, 1, 0, 1);

    // M1 backpressure with RREADY toggling
    applyStimulus(2'b10, 7, 8, 1, 0);

    // early last, then clean bursts keep the sticky flag
    applyStimulus(2'b01, 3, 2, 0, 0);
    applyStimulus(2'b10, 2, 3, 0, 0);
    applyStimulus(2'b01, 0, 1, 1, 2);

    // missing last from a clean flag
    doReset();
    applyStimulus(2'b10, 1, 255, 0, 0);
    applyStimulus(2'b01, 1, 2, 0, 0);

    // reset in the middle of an M1 burst after an M0 burst
    doReset();
    applyStimulus(2'b01, 1, 2, 0, 0);
    M1_ARADDR = 32'h0000_2000; M1_ARLEN = 8'd5; M1_ARVALID = 1; S_ARREADY = 1;
    tick();
    tick();
    M1_ARVALID = 0; S_ARREADY = 0;
    S_RVALID = 1; S_RDATA = 32'hDEAD_BEEF; S_RLAST = 0; M1_RREADY = 1;
    M0_ARVALID = 1;
    #1;
    checkOutput("midburst busy", busy, 1);
    checkOutput("midburst rdata", M1_RDATA, 32'hDEAD_BEEF);
    ARESET = 1;
    tick();
    #1;
    checkReset("midburst reset");
    clearInputs();
    ARESET = 0;
    modelLast = 1'b1;
    modelErr = 1'b0;
    applyStimulus(2'b11, 2, 3, 0, 0);

    // randomized bursts against the same rules
    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(0, 7);
      applyStimulus(2'($urandom_range(1, 3)), len,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : len + 1,
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
